// File: rtl/mod_addsub_pkg.sv
// Shared constants and state encoding for the word-serial modular adder/subtractor.
package mod_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int WORD_W_DEF = 16;
    localparam int NWORDS_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        PASS1,
        PASS2,
        OUT
    } state_t;

endpackage

// File: rtl/mod_shreg.sv
// Cyclic word shift register: shifts din in at the MSW end, or rotates the LSW back to the MSW end.
module mod_shreg #(
    parameter int WORD_W = 16,
    parameter int NWORDS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              rot,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] q
);

    logic [WORD_W-1:0] words [NWORDS];

    // A write takes priority over a rotate; both move every word one step toward the LSW.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NWORDS; i++) begin
                words[i] <= '0;
            end
        end else if (we || rot) begin
            for (int i = 0; i < NWORDS - 1; i++) begin
                words[i] <= words[i+1];
            end
            words[NWORDS-1] <= we ? din : words[0];
        end
    end

    assign q = words[0];

endmodule

// File: rtl/mod_addsub_serial.sv
// Word-serial (a +/- b) mod p over NWORDS x WORD_W-bit operands.
// Optional status ports corr_flag/carry_out are built when MODAS_STATUS_EN is defined.
module mod_addsub_serial
    import mod_addsub_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int NWORDS = NWORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] din,
    input  logic              load_a,
    input  logic              load_b,
    input  logic              load_p,
    input  logic              start,
    input  logic              op,
    output logic              busy,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    output logic              done
`ifdef MODAS_STATUS_EN
    ,
    output logic              corr_flag,
    output logic              carry_out
`endif
);

    localparam int              CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              op_q;
    logic              carry;
    logic              c1;
    logic              c2;
    logic              corr;
    logic              last;
    logic              idle;
    logic              in_pass1;
    logic              in_pass2;
    logic              in_out;
    logic              rot_ops;
    logic [WORD_W-1:0] a_q;
    logic [WORD_W-1:0] b_q;
    logic [WORD_W-1:0] p_q;
    logic [WORD_W-1:0] s0_q;
    logic [WORD_W-1:0] s1_q;
    logic [WORD_W-1:0] add_x;
    logic [WORD_W-1:0] add_y;
    logic [WORD_W-1:0] sum;
    logic              add_cin;
    logic              add_cout;

    assign idle     = (state == IDLE);
    assign in_pass1 = (state == PASS1);
    assign in_pass2 = (state == PASS2);
    assign in_out   = (state == OUT);
    assign last     = (cnt == CNT_LAST);
    assign rot_ops  = in_pass1 | in_pass2;

    // Operands rotate a full turn in each pass so they are intact for the next start.
    mod_shreg #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_reg_a (
        .clk(clk), .rst(rst), .we(idle & load_a), .rot(rot_ops), .din(din), .q(a_q)
    );
    mod_shreg #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_reg_b (
        .clk(clk), .rst(rst), .we(idle & load_b), .rot(rot_ops), .din(din), .q(b_q)
    );
    mod_shreg #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_reg_p (
        .clk(clk), .rst(rst), .we(idle & load_p), .rot(rot_ops), .din(din), .q(p_q)
    );
    mod_shreg #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_reg_s0 (
        .clk(clk), .rst(rst), .we(in_pass1), .rot(in_pass2 | in_out), .din(sum), .q(s0_q)
    );
    mod_shreg #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_reg_s1 (
        .clk(clk), .rst(rst), .we(in_pass2), .rot(in_out), .din(sum), .q(s1_q)
    );

    // Subtraction is addition of the one's complement with a carry-in of one on word 0.
    always_comb begin
        add_x   = a_q;
        add_y   = b_q ^ {WORD_W{op_q}};
        add_cin = op_q;
        if (in_pass2) begin
            add_x   = s0_q;
            add_y   = p_q ^ {WORD_W{~op_q}};
            add_cin = ~op_q;
        end
        if (cnt != '0) begin
            add_cin = carry;
        end
    end

    assign {add_cout, sum} = {1'b0, add_x} + {1'b0, add_y} + {{WORD_W{1'b0}}, add_cin};

    assign corr = (op_q == OP_SUB) ? ~c1 : (c1 | c2);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            op_q  <= OP_ADD;
            carry <= 1'b0;
            c1    <= 1'b0;
            c2    <= 1'b0;
        end else begin
            if (idle) begin
                cnt <= '0;
                if (start) begin
                    op_q <= op;
                end
            end else begin
                cnt <= last ? '0 : cnt + CNT_W'(1);
            end
            if (rot_ops) begin
                carry <= add_cout;
            end
            if (in_pass1 && last) begin
                c1 <= add_cout;
            end
            if (in_pass2 && last) begin
                c2 <= add_cout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PASS1;
            PASS1:   if (last)  state_next = PASS2;
            PASS2:   if (last)  state_next = OUT;
            OUT:     if (last)  state_next = IDLE;
            default:            state_next = IDLE;
        endcase
    end

    // All outputs decode registered state, so they are glitch-free relative to the clock.
    always_comb begin
        busy       = !idle;
        dout_valid = in_out;
        done       = in_out && last;
        dout       = '0;
        if (in_out) begin
            dout = corr ? s1_q : s0_q;
        end
`ifdef MODAS_STATUS_EN
        corr_flag = in_out && last && corr;
        carry_out = in_out && last && c1;
`endif
    end

endmodule

// File: tb/tb_mod_addsub_serial.sv
// Scoreboard testbench for mod_addsub_serial: randomized and directed operations checked
// against a 256-bit arithmetic reference model. Status ports are checked when MODAS_STATUS_EN is set.
module tb_mod_addsub_serial;

    localparam int W   = 16;
    localparam int N   = 16;
    localparam int OPW = W * N;

    typedef struct {
        logic [W-1:0] word;
        logic         last;
        logic         corr;
        logic         cout;
        int           start_edge;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         load_a;
    logic         load_b;
    logic         load_p;
    logic         start;
    logic         op;
    logic         busy;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         done;
`ifdef MODAS_STATUS_EN
    logic         corr_flag;
    logic         carry_out;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    exp_t sb[$];
    exp_t mon_item;

    logic [OPW-1:0] model_a;
    logic [OPW-1:0] model_b;
    logic [OPW-1:0] model_p;

    mod_addsub_serial #(.WORD_W(W), .NWORDS(N)) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .load_a(load_a),
        .load_b(load_b),
        .load_p(load_p),
        .start(start),
        .op(op),
        .busy(busy),
        .dout(dout),
        .dout_valid(dout_valid),
        .done(done)
`ifdef MODAS_STATUS_EN
        ,
        .corr_flag(corr_flag),
        .carry_out(carry_out)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [OPW-1:0] rand_wide();
        logic [OPW-1:0] r;
        for (int i = 0; i < OPW / 32; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    // Reference: true modular result from wide arithmetic.
    function automatic logic [OPW-1:0] ref_result(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                                  input logic [OPW-1:0] p, input logic sub);
        logic [OPW:0] t;
        if (!sub) begin
            t = ({1'b0, a} + {1'b0, b}) % {1'b0, p};
        end else begin
            t = ({1'b0, a} + {1'b0, p} - {1'b0, b}) % {1'b0, p};
        end
        return t[OPW-1:0];
    endfunction

    task automatic doLoad(input logic la, input logic lb, input logic lp, input logic [OPW-1:0] val);
        for (int i = 0; i < N; i++) begin
            din    = val[i*W +: W];
            load_a = la;
            load_b = lb;
            load_p = lp;
            @(posedge clk);
            #1;
        end
        load_a = 1'b0;
        load_b = 1'b0;
        load_p = 1'b0;
        din    = '0;
        if (la) model_a = val;
        if (lb) model_b = val;
        if (lp) model_p = val;
    endtask

    task automatic applyStimulus(input logic op_in, input bit expect_result,
                                 input int disturb_at, input int abort_at);
        int             start_edge;
        bit             aborted;
        logic [OPW-1:0] res;
        logic [OPW:0]   wide;
        exp_t           e;
        aborted = 1'b0;
        start   = 1'b1;
        op      = op_in;
        @(posedge clk);
        #1;
        start      = 1'b0;
        op         = 1'($urandom_range(0, 1));
        start_edge = cyc;
        checkOutput("busy_after_start", 64'(busy), 64'(1));
        if (expect_result) begin
            res  = ref_result(model_a, model_b, model_p, op_in);
            wide = {1'b0, model_a} + {1'b0, model_b};
            for (int i = 0; i < N; i++) begin
                e.word       = res[i*W +: W];
                e.last       = (i == N - 1);
                e.corr       = op_in ? (model_a < model_b) : (wide >= {1'b0, model_p});
                e.cout       = op_in ? (model_a >= model_b) : wide[OPW];
                e.start_edge = start_edge;
                sb.push_back(e);
            end
        end
        for (int t = 1; t < 3 * N; t++) begin
            if (t == disturb_at) begin
                start  = 1'b1;
                load_a = 1'b1;
                din    = W'($urandom);
                op     = ~op_in;
            end
            if (t == abort_at) rst = 1'b1;
            @(posedge clk);
            #1;
            start  = 1'b0;
            load_a = 1'b0;
            din    = '0;
            if (t == abort_at) begin
                rst     = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            @(negedge clk);
            checkOutput("abort_busy", 64'(busy), 64'(0));
            checkOutput("abort_dout_valid", 64'(dout_valid), 64'(0));
            checkOutput("abort_done", 64'(done), 64'(0));
            checkOutput("abort_dout", 64'(dout), 64'(0));
            model_a = '0;
            model_b = '0;
            model_p = '0;
            repeat (3 * N) @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
            checkOutput("busy_idle_after_op", 64'(busy), 64'(0));
        end
    endtask

    // Monitor: every presented result word is matched against the oldest expected word.
    always @(negedge clk) begin
        if (!rst) begin
            if (dout_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_word", 64'(dout_valid), 64'(0));
                end else begin
                    mon_item = sb.pop_front();
                    checkOutput("dout_word", 64'(dout), 64'(mon_item.word));
                    checkOutput("done_with_last", 64'(done), 64'(mon_item.last));
                    if (mon_item.last) begin
                        checkOutput("done_latency", 64'(cyc + 1 - mon_item.start_edge), 64'(3 * N));
                    end
`ifdef MODAS_STATUS_EN
                    checkOutput("corr_flag", 64'(corr_flag), 64'(mon_item.last & mon_item.corr));
                    checkOutput("carry_out", 64'(carry_out), 64'(mon_item.last & mon_item.cout));
`endif
                end
            end else if (done) begin
                checkOutput("done_without_valid", 64'(done), 64'(0));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [OPW-1:0] p_big;
        logic [OPW-1:0] v;
        rst    = 1'b1;
        din    = '0;
        load_a = 1'b0;
        load_b = 1'b0;
        load_p = 1'b0;
        start  = 1'b0;
        op     = 1'b0;
        model_a = '0;
        model_b = '0;
        model_p = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_dout_valid", 64'(dout_valid), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_dout", 64'(dout), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] directed small-value cases");
        v = OPW'(5);  doLoad(1'b1, 1'b0, 1'b0, v);
        v = OPW'(7);  doLoad(1'b0, 1'b1, 1'b0, v);
        v = OPW'(13); doLoad(1'b0, 1'b0, 1'b1, v);
        applyStimulus(1'b0, 1'b1, 0, 0);
        v = OPW'(10); doLoad(1'b1, 1'b0, 1'b0, v);
        applyStimulus(1'b0, 1'b1, 0, 0);
        v = OPW'(3);  doLoad(1'b1, 1'b0, 1'b0, v);
        applyStimulus(1'b1, 1'b1, 0, 0);
        applyStimulus(1'b0, 1'b1, 0, 0);

        $display("[TB] full-width carry-out case");
        p_big = '1;
        p_big = p_big - OPW'(188);
        doLoad(1'b0, 1'b0, 1'b1, p_big);
        doLoad(1'b1, 1'b1, 1'b0, p_big - OPW'(1));
        applyStimulus(1'b0, 1'b1, 0, 0);
        applyStimulus(1'b1, 1'b1, 0, 0);

        $display("[TB] inputs ignored while busy");
        v = OPW'(3);  doLoad(1'b1, 1'b0, 1'b0, v);
        v = OPW'(7);  doLoad(1'b0, 1'b1, 1'b0, v);
        v = OPW'(13); doLoad(1'b0, 1'b0, 1'b1, v);
        applyStimulus(1'b1, 1'b1, 5, 0);
        repeat (N) @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 0, 0);

        $display("[TB] randomized operations");
        for (int it = 0; it < 10; it++) begin
            if (it == 0 || $urandom_range(0, 3) != 0) begin
                p_big = rand_wide();
                if ($urandom_range(0, 2) == 0) p_big = p_big >> $urandom_range(1, OPW - 8);
                p_big = p_big | OPW'(2);
                doLoad(1'b0, 1'b0, 1'b1, p_big);
                doLoad(1'b1, 1'b0, 1'b0, rand_wide() % p_big);
                doLoad(1'b0, 1'b1, 1'b0, rand_wide() % p_big);
            end
            applyStimulus(1'($urandom_range(0, 1)), 1'b1, 0, 0);
        end

        $display("[TB] reset in the middle of the second pass");
        applyStimulus(1'b0, 1'b0, 0, 20);
        v = OPW'(10); doLoad(1'b1, 1'b0, 1'b0, v);
        v = OPW'(7);  doLoad(1'b0, 1'b1, 1'b0, v);
        v = OPW'(13); doLoad(1'b0, 1'b0, 1'b1, v);
        applyStimulus(1'b0, 1'b1, 0, 0);

        repeat (3 * N) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
